// File: rtl/credit_out_buffer.sv
// Credit-controlled output buffer behind a fixed-latency, non-stallable delay stage.
// Optional sticky overflow flag is built when CREDIT_BUF_OVERFLOW_CHECK_EN is defined.
module credit_out_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         issue_valid,
  output logic                         issue_ready,
  input  logic                         s_valid,
  input  logic [DATA_WIDTH-1:0]        s_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [DATA_WIDTH-1:0]        m_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         reserved;
  logic                  issue, pop, full, wr;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign issue_ready = (reserved != FULL);
  assign m_valid     = (count != '0);
  assign m_data      = mem[rd_ptr];
  assign issue       = issue_valid && issue_ready;
  assign pop         = m_valid && m_ready;
  assign full        = (count == FULL);
  // A pop frees the slot against pre-edge state, so a full buffer still accepts a write.
  assign wr          = s_valid && (!full || pop);

  // Credits: stored plus in-flight words; held at zero if pops outrun issues.
  always_ff @(posedge clk) begin
    if (rst) begin
      reserved <= '0;
    end else if (issue && !pop) begin
      reserved <= reserved + 1'b1;
    end else if (pop && !issue && reserved != '0) begin
      reserved <= reserved - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr)  wr_ptr <= bump(wr_ptr);
      if (pop) rd_ptr <= bump(rd_ptr);
      if (wr && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !wr) begin
        count <= count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= s_data;
  end

`ifdef CREDIT_BUF_OVERFLOW_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (s_valid && full && !pop) begin
      overflow <= 1'b1;
    end
  end
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_credit_out_buffer.sv
// Directed bench for credit_out_buffer: DEPTH=4 behind a 2-level delay-stage model,
// plus a DEPTH=3 instance driven directly for pointer-wrap checks.
module tb_credit_out_buffer;

  logic       clk = 1'b0;
  logic       rst;
  always #5 clk = ~clk;

`ifdef CREDIT_BUF_OVERFLOW_CHECK_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  // DEPTH=4 instance
  logic       issue_valid, issue_ready, s_valid, m_valid, m_ready, overflow;
  logic [7:0] issue_data, s_data, m_data;
  logic [2:0] count;
  logic       force_en, f_v;
  logic [7:0] f_d;

  // LEVEL=2 delay-stage model
  logic       p0_v, p1_v;
  logic [7:0] p0_d, p1_d;
  always @(posedge clk) begin
    if (rst) begin
      p0_v <= 1'b0;
      p1_v <= 1'b0;
    end else begin
      p0_v <= issue_valid && issue_ready;
      p0_d <= issue_data;
      p1_v <= p0_v;
      p1_d <= p0_d;
    end
  end
  assign s_valid = force_en ? f_v : p1_v;
  assign s_data  = force_en ? f_d : p1_d;

  credit_out_buffer #(.DATA_WIDTH(8), .DEPTH(4)) u_dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .s_valid(s_valid), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .count(count), .overflow(overflow)
  );

  // DEPTH=3 instance
  logic       b_issue_valid, b_issue_ready, b_s_valid, b_m_valid, b_m_ready, b_overflow;
  logic [7:0] b_s_data, b_m_data;
  logic [1:0] b_count;

  credit_out_buffer #(.DATA_WIDTH(8), .DEPTH(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .issue_valid(b_issue_valid), .issue_ready(b_issue_ready),
    .s_valid(b_s_valid), .s_data(b_s_data),
    .m_valid(b_m_valid), .m_ready(b_m_ready), .m_data(b_m_data),
    .count(b_count), .overflow(b_overflow)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int issued, acc, first, last;
    logic [7:0] exp;

    rst = 1'b1; issue_valid = 1'b0; issue_data = '0; m_ready = 1'b0;
    force_en = 1'b0; f_v = 1'b0; f_d = '0;
    b_issue_valid = 1'b0; b_s_valid = 1'b0; b_s_data = '0; b_m_ready = 1'b0;

    // Reset
    repeat (3) step();
    check("rst_issue_ready", issue_ready, 1);
    check("rst_m_valid", m_valid, 0);
    check("rst_count", count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_b_count", b_count, 0);
    rst = 1'b0;
    step();

    // Streaming 0x01..0x10 with m_ready held high
    m_ready = 1'b1; issued = 0; exp = 8'h01; first = -1; last = -1;
    for (int cyc = 0; cyc < 24; cyc++) begin
      issue_valid = (issued < 16);
      issue_data  = 8'(issued + 1);
      if (issue_valid) check("stream_issue_ready", issue_ready, 1);
      if (m_valid) begin
        check("stream_data", m_data, exp);
        exp++;
        if (first < 0) first = cyc;
        last = cyc;
      end
      if (issue_valid && issue_ready) issued++;
      step();
    end
    issue_valid = 1'b0;
    check("stream_words", exp, 8'h11);
    check("stream_gapless", last - first, 15);
    check("stream_empty", m_valid, 0);

    // Backpressure: only DEPTH credits granted
    m_ready = 1'b0; acc = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      issue_valid = 1'b1;
      issue_data  = 8'(8'h21 + acc);
      if (acc == 4) check("bp_credit_stop", issue_ready, 0);
      if (issue_ready) acc++;
      step();
    end
    check("bp_accepted", acc, 4);
    check("bp_count", count, 4);
    check("bp_overflow", overflow, 0);
    check("bp_head", m_data, 8'h21);
    m_ready = 1'b1;
    check("bp_pop_cycle_ready", issue_ready, 0);
    step();
    m_ready = 1'b0; issue_valid = 1'b0;
    check("bp_credit_back", issue_ready, 1);
    check("bp_count_after_pop", count, 3);
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("bp_drain", m_data, 8'(8'h22 + i));
      step();
    end
    m_ready = 1'b0;
    check("bp_drained", m_valid, 0);

    // Overflow: write while full without a pop
    force_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      f_v = 1'b1; f_d = 8'(8'h31 + i);
      step();
    end
    check("ovf_full_count", count, 4);
    check("ovf_before", overflow, 0);
    f_d = 8'hAA;
    step();
    f_v = 1'b0;
    check("ovf_set", overflow, OVF_EXP);
    step(); step();
    check("ovf_sticky", overflow, OVF_EXP);
    check("ovf_count", count, 4);
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("ovf_drain", m_data, 8'(8'h31 + i));
      step();
    end
    check("ovf_drained", m_valid, 0);
    m_ready = 1'b0; force_en = 1'b0;

    // Reset mid-operation: two stored, one in flight
    issue_valid = 1'b1; issue_data = 8'h41; step();
    issue_data = 8'h42; step();
    issue_data = 8'h43; step();
    issue_valid = 1'b0; step();
    check("midrst_count_pre", count, 2);
    rst = 1'b1; step();
    check("midrst_m_valid", m_valid, 0);
    check("midrst_count", count, 0);
    check("midrst_issue_ready", issue_ready, 1);
    check("midrst_overflow", overflow, 0);
    rst = 1'b0;
    m_ready = 1'b1; issued = 0; exp = 8'h51;
    for (int cyc = 0; cyc < 10; cyc++) begin
      issue_valid = (issued < 2);
      issue_data  = 8'(8'h51 + issued);
      if (m_valid) begin
        check("midrst_data", m_data, exp);
        exp++;
      end
      if (issue_valid && issue_ready) issued++;
      step();
    end
    issue_valid = 1'b0;
    check("midrst_words", exp, 8'h53);

    // DEPTH=3: hold full with simultaneous write and pop across pointer wrap
    for (int i = 0; i < 3; i++) begin
      b_s_valid = 1'b1; b_s_data = 8'(8'h61 + i);
      step();
    end
    check("wrap_full", b_count, 3);
    b_m_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      b_s_data = 8'(8'h64 + i);
      check("wrap_data", b_m_data, 8'(8'h61 + i));
      step();
      check("wrap_count", b_count, 3);
    end
    b_s_valid = 1'b0;
    check("wrap_overflow", b_overflow, 0);
    for (int i = 0; i < 3; i++) begin
      check("wrap_drain", b_m_data, 8'(8'h66 + i));
      step();
    end
    check("wrap_drained", b_m_valid, 0);
    b_m_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/credit_out_buffer.md
# credit_out_buffer

Credit-controlled output buffer that sits directly downstream of the fixed-latency, non-stallable pipeline delay stage. Data leaving the delay line cannot be stalled, so this block grants issue permission upstream only while a slot is reserved for every word in flight. It then presents the stored words to a valid/ready consumer, letting the KAN datapath tolerate backpressure without loss.

## Interface
- DATA_WIDTH, 8, width of each data word (equals the delay stage's DATA_WIDTH)
- DEPTH, 4, buffer entries; any integer ≥1; full throughput requires DEPTH ≥ delay-stage LEVEL + 1
- clk  input  1  clock, all state on rising edge
- rst  input  1  reset, synchronous, active-high
- issue_valid  input  1  producer wants to inject a word into the delay stage this cycle
- issue_ready  output  1  credit available; an issue occurs when issue_valid && issue_ready
- s_valid  input  1  word arriving from the delay stage output
- s_data  input  DATA_WIDTH  data from the delay stage output
- m_valid  output  1  buffer holds at least one word
- m_ready  input  1  consumer accepts m_data
- m_data  output  DATA_WIDTH  oldest stored word
- count  output  $clog2(DEPTH+1)  words currently stored (not including in flight)
- overflow  output  1  sticky error: s_valid arrived while the buffer was full

## Operation
- `reserved` counter, range 0..DEPTH: number of stored words plus in-flight words.
  - +1 on issue.
  - −1 on pop (m_valid && m_ready).
  - Unchanged when both happen in the same cycle.
- issue_ready = (reserved != DEPTH).
  - Depends only on registered state, with no combinational path from m_ready.
  - A pop in the same cycle does not free a credit until the next cycle.
- Storage is a circular buffer with wr_ptr, rd_ptr and count.
  - Pointers wrap DEPTH−1 → 0; DEPTH is not required to be a power of two.
- Write: when s_valid, store s_data at wr_ptr and advance wr_ptr.
  - If count == DEPTH, drop the word, leave pointers unchanged and raise overflow (see Configuration).
- Read: m_valid = (count != 0); m_data = mem[rd_ptr] (fall-through).
  - A pop advances rd_ptr.
- Simultaneous write and pop: both take effect; count is unchanged.
  - This is legal when count == DEPTH, because the pop is evaluated against pre-edge state, so no overflow.
- No bypass: a word written into an empty buffer becomes visible the following cycle.
- s_valid without a prior issue is a protocol error.
  - The word is still stored if there is space.
  - `reserved` is not adjusted.
  - Not flagged.

## Timing
- Reset values:
  - issue_ready = 1 (DEPTH ≥ 1)
  - m_valid = 0
  - count = 0
  - overflow = 0
  - m_data = don't-care; stored contents are not cleared
  - internal: reserved = 0, pointers = 0
- Reset mid-operation discards stored and in-flight accounting.
  - The delay stage must be reset in the same cycle; its reset flushes in-flight words.
- Latency: s_valid at edge N → m_valid high after edge N+1 (one cycle).
- Credit round trip: a pop at edge N raises issue_ready after edge N+1.
- Throughput: one word per cycle sustained when m_ready is held high and DEPTH ≥ LEVEL+1.
- m_data is stable while m_valid && !m_ready.

## Configuration
- CREDIT_BUF_OVERFLOW_CHECK_EN defined:
  - overflow is a sticky register, set on a write to a full buffer and cleared only by rst.
  - The dropped word is discarded.
- Not defined:
  - overflow is tied to 0 and no checking logic is built.
  - Writes to a full buffer are still dropped; pointers are unaffected.

## Test plan
- Reset check: assert rst for 3 cycles → issue_ready=1, m_valid=0, count=0, overflow=0.
- Streaming, DEPTH=4 with LEVEL=2 delay stage, m_ready=1: issue words 0x01..0x10 back to back → m_data sequence 0x01..0x10 in order, no gaps after fill, issue_ready never drops.
- Backpressure: m_ready=0 while issue_valid=1 continuously → exactly 4 issues accepted; issue_ready=0 from the cycle reserved hits 4; count reaches 4; no overflow. Then m_ready=1 for one cycle → one pop, issue_ready=1 the next cycle.
- Wrap-around and simultaneous events, DEPTH=3: hold count=3 and present s_valid together with a pop for 5 cycles → count stays 3, FIFO order preserved across pointer wrap, overflow=0.
- Overflow (macro defined): force s_valid=1 with data 0xAA while count=DEPTH and m_ready=0 → overflow=1 next cycle and stays high, 0xAA never appears on m_data. Macro undefined: same stimulus → overflow=0, 0xAA dropped.
- Reset mid-operation: count=2 and 1 word in flight, assert rst → next cycle m_valid=0, count=0, issue_ready=1; after release, new words flow correctly.
